uart_tx_arbiter: RTL

- Shares one UART transmitter (11-bit frame: start, 8 data, parity, stop; 868 sys_clk per bit) between NUM_REQ byte producers.
- Round-robin arbitration with a one-byte-per-grant handshake. Sequences the transmitter's start/done protocol, with a watchdog for a hung transmitter.
- Sits between on-chip byte sources (command responders, status reporters) and the UART TX serializer.

---
 rtl/uart_tx_arbiter_if.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte requesters, uart_tx_arbiter and the UART serializer.
// The req_last vector exists only when UART_TX_ARB_LOCK_EN is defined.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  // Requester i holds req_valid[i] and its byte until req_ready[i] is high for one
  // cycle; the byte is taken on that edge. tx_start is a one-cycle pulse, tx_data
  // stays stable until the transmitter answers with a one-cycle tx_done.
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
`ifdef UART_TX_ARB_LOCK_EN
  logic [NUM_REQ-1:0]            req_last;
`endif
  logic                          tx_start;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic                          tx_done;

`ifdef UART_TX_ARB_LOCK_EN
  modport slave  (input  req_valid, req_data, req_last, tx_done,
                  output req_ready, tx_start, tx_data);
  modport master (output req_valid, req_data, req_last, tx_done,
                  input  req_ready, tx_start, tx_data);
`else
  modport slave  (input  req_valid, req_data, tx_done,
                  output req_ready, tx_start, tx_data);
  modport master (output req_valid, req_data, tx_done,
                  input  req_ready, tx_start, tx_data);
`endif
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Optional packet locking (multi-byte atomic grants) is enabled by UART_TX_ARB_LOCK_EN.
module uart_tx_arbiter #(
  parameter int  NUM_REQ     = 4,
  parameter int  DATA_WIDTH  = 8,
  parameter int  TIMEOUT_CYC = 12000,
  localparam int IdW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int WdW         = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  uart_tx_arbiter_if.slave bus,
  output logic [IdW-1:0]   grant_id_o,
  output logic             busy_o,
  output logic             timeout_err_o,
  output logic [2:0]       state_o
);

  // state_o exposes the raw encoding; IDLE is 0.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3
`ifdef UART_TX_ARB_LOCK_EN
    , S_HOLD = 3'd4
`endif
  } state_e;

  state_e                state_q;
  logic [NUM_REQ-1:0]    ready_q;
  logic                  start_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic [IdW-1:0]        grant_q;
  logic [IdW-1:0]        last_grant_q;
  logic                  busy_q;
  logic                  tout_q;
  logic [WdW-1:0]        wdog_q;
`ifdef UART_TX_ARB_LOCK_EN
  logic                  last_q;
`endif

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [IdW-1:0]        winner_d;
  logic                  found_d;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IdW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Scan starts one past the last granted requester and wraps.
  always_comb begin
    logic [IdW-1:0] cand;
    winner_d = '0;
    found_d  = 1'b0;
    cand     = last_grant_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == IdW'(NUM_REQ - 1)) ? '0 : cand + IdW'(1);
      if (!found_d && bus.req_valid[cand]) begin
        winner_d = cand;
        found_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= S_IDLE;
      ready_q      <= '0;
      start_q      <= 1'b0;
      tx_data_q    <= '0;
      grant_q      <= '0;
      last_grant_q <= IdW'(NUM_REQ - 1);
      busy_q       <= 1'b0;
      tout_q       <= 1'b0;
      wdog_q       <= '0;
`ifdef UART_TX_ARB_LOCK_EN
      last_q       <= 1'b1;
`endif
    end else begin
      start_q <= 1'b0;
      tout_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (found_d) begin
            grant_q <= winner_d;
            ready_q <= onehot(winner_d);
            busy_q  <= 1'b1;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          ready_q <= '0;
          if (bus.req_valid[grant_q]) begin
            tx_data_q <= data_arr[grant_q];
            start_q   <= 1'b1;
`ifdef UART_TX_ARB_LOCK_EN
            last_q    <= bus.req_last[grant_q];
`endif
            state_q   <= S_START;
          end else begin
            // Requester withdrew: nothing sent, round-robin pointer untouched.
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_START: begin
          wdog_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          wdog_q <= wdog_q + WdW'(1);
          if (bus.tx_done) begin
            last_grant_q <= grant_q;
`ifdef UART_TX_ARB_LOCK_EN
            if (!last_q) begin
              state_q <= S_HOLD;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
`else
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
`endif
          end else if (wdog_q == WdW'(TIMEOUT_CYC - 1)) begin
            // Hung transmitter: drop the byte, release any packet lock.
            tout_q       <= 1'b1;
            last_grant_q <= grant_q;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
`ifdef UART_TX_ARB_LOCK_EN
        S_HOLD: begin
          if (bus.req_valid[grant_q]) begin
            ready_q <= onehot(grant_q);
            state_q <= S_GRANT;
          end
        end
`endif
        default: begin
          ready_q <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready   = ready_q;
  assign bus.tx_start    = start_q;
  assign bus.tx_data     = tx_data_q;
  assign grant_id_o      = grant_q;
  assign busy_o          = busy_q;
  assign timeout_err_o   = tout_q;
  assign state_o         = state_q;

endmodule
